inst_fetch: RTL



---
 rtl/inst_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch front end with PC, single-word memory reads and an in-order instruction queue.
// Optional JAL next-PC prediction is enabled by defining IFETCH_JAL_PREDICT_EN.
`default_nettype none

module inst_fetch #(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  output logic        mc_reset,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic        dq_valid,
  output logic [31:0] dq_inst,
  output logic [31:0] dq_pc,
  output logic [31:0] dq_pred_pc,
  input  logic        dq_pop
);

  localparam int            PW        = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_CNT = IQ_DEPTH[PW:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [31:0]     r_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic [PW:0]     w_count_nx;
  logic [31:0]     r_q_inst [IQ_DEPTH];
  logic [31:0]     r_q_pc   [IQ_DEPTH];
  logic [31:0]     r_q_pred [IQ_DEPTH];
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_npc;

`ifdef IFETCH_JAL_PREDICT_EN
  logic [31:0] w_jal_imm;
  assign w_jal_imm = {{11{mc_data[31]}}, mc_data[31], mc_data[19:12],
                      mc_data[20], mc_data[30:21], 1'b0};
  assign w_npc = (mc_data[6:0] == 7'b1101111) ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
`else
  assign w_npc = r_pc + 32'd4;
`endif

  // A returned word in the flush cycle belongs to the abandoned path and is dropped.
  assign w_push     = (r_state == S_WAIT) && mc_done && !flush;
  assign w_pop      = dq_pop && (r_count != '0) && !flush;
  assign w_count_nx = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

  assign mc_req     = (r_state == S_WAIT) && !mc_done && !flush;
  assign mc_addr    = r_pc;
  assign mc_reset   = flush;
  assign dq_valid   = (r_count != '0);
  assign dq_inst    = r_q_inst[r_head];
  assign dq_pc      = r_q_pc[r_head];
  assign dq_pred_pc = r_q_pred[r_head];

  always_comb begin
    w_state_nx = r_state;
    if (flush) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (r_count < DEPTH_CNT) w_state_nx = S_WAIT;
        S_WAIT: if (mc_done) w_state_nx = (w_count_nx < DEPTH_CNT) ? S_WAIT : S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
        r_q_pred[i] <= '0;
      end
    end else if (rdy) begin
      r_state <= w_state_nx;
      if (flush) begin
        r_pc    <= flush_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_q_inst[r_tail] <= mc_data;
          r_q_pc[r_tail]   <= r_pc;
          r_q_pred[r_tail] <= w_npc;
          r_tail           <= r_tail + 1'b1;
          r_pc             <= w_npc;
        end
        if (w_pop) r_head <= r_head + 1'b1;
        r_count <= w_count_nx;
      end
    end
  end

endmodule

`default_nettype wire
